// File: rtl/cpu_pkg.sv
// Shared opcode encodings and sequencer state type for the 9-bit core.
// The control decoder uses the same opcode constants.
package cpu_pkg;

    localparam logic [3:0] OP_CMP  = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1001;
    localparam logic [3:0] OP_BGT  = 4'b1010;
    localparam logic [3:0] OP_BLT  = 4'b1011;
    localparam logic [3:0] OP_BR   = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/branch_lut.sv
// Branch target table: one synchronous write port and one asynchronous read port.
// A same-cycle write and read to one index returns the old entry.
module branch_lut #(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 32,
    parameter int ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [PC_W-1:0]   wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [PC_W-1:0]   rdata
);

    logic [PC_W-1:0] mem [LUT_DEPTH];

    // Contents are deliberately not reset; software loads the table before use.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_sequencer.sv
// Front end of the 9-bit core: program counter, CMP flags, run/halt control
// and branch target resolution through a loadable lookup table.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 32,
    parameter int CNT_W     = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       Opcode,
    input  logic [4:0]       TargetIdx,
    input  logic             Branch,
    input  logic             Halt,
    input  logic             AluEq,
    input  logic             AluGt,
    input  logic             AluLt,
    input  logic             LutWe,
    input  logic [4:0]       LutAddr,
    input  logic [PC_W-1:0]  LutData,
    output logic [PC_W-1:0]  InstAddr,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount
);

    seq_state_t       state;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  lut_target;
    logic [CNT_W-1:0] cycle_cnt;
    logic             flag_eq;
    logic             flag_gt;
    logic             flag_lt;
    logic             taken;
    logic             cmp_en;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    branch_lut #(
        .PC_W      (PC_W),
        .LUT_DEPTH (LUT_DEPTH),
        .ADDR_W    (5)
    ) u_lut (
        .clk   (Clk),
        .we    (LutWe),
        .waddr (LutAddr),
        .wdata (LutData),
        .raddr (TargetIdx),
        .rdata (lut_target)
    );

    // Branch decisions always see the flags registered by an earlier CMP.
    always_comb begin
        taken = 1'b0;
        if (Branch) begin
            case (Opcode)
                OP_BEQ:  taken = flag_eq;
                OP_BGT:  taken = flag_gt;
                OP_BLT:  taken = flag_lt;
                OP_BR:   taken = 1'b1;
                default: taken = 1'b0;
            endcase
        end
        cmp_en = (Opcode == OP_CMP) && !Halt;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            pc        <= '0;
            flag_eq   <= 1'b0;
            flag_gt   <= 1'b0;
            flag_lt   <= 1'b0;
            cycle_cnt <= '0;
            Running   <= 1'b0;
            Done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        state     <= RUN;
                        pc        <= '0;
                        flag_eq   <= 1'b0;
                        flag_gt   <= 1'b0;
                        flag_lt   <= 1'b0;
                        cycle_cnt <= '0;
                        Running   <= 1'b1;
                        Done      <= 1'b0;
                    end
                end
                RUN: begin
                    if (Start) begin
                        pc        <= '0;
                        flag_eq   <= 1'b0;
                        flag_gt   <= 1'b0;
                        flag_lt   <= 1'b0;
                        cycle_cnt <= '0;
                    end else begin
                        // The halt cycle itself still counts as a run cycle.
                        cycle_cnt <= sat_inc(cycle_cnt);
                        if (Halt) begin
                            state   <= DONE;
                            Running <= 1'b0;
                            Done    <= 1'b1;
                        end else begin
                            if (cmp_en) begin
                                flag_eq <= AluEq;
                                flag_gt <= AluGt;
                                flag_lt <= AluLt;
                            end
                            pc <= taken ? lut_target : pc + PC_W'(1);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    Running <= 1'b0;
                    Done    <= 1'b0;
                end
            endcase
        end
    end

    assign InstAddr   = pc;
    assign CycleCount = cycle_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scenario bench for fetch_sequencer: expected outputs are queued as stimulus
// is driven and popped one cycle later when the registered outputs settle.
module tb_fetch_sequencer;
    import cpu_pkg::*;

    typedef struct packed {
        logic [9:0]  addr;
        logic        run;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    typedef struct packed {
        logic       start;
        logic       halt;
        logic       branch;
        logic [3:0] op;
        logic [4:0] idx;
        logic       eq;
        logic       gt;
        logic       lt;
        logic       we;
        logic [4:0] waddr;
        logic [9:0] wdata;
    } stim_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [3:0]  Opcode = 4'd0;
    logic [4:0]  TargetIdx = 5'd0;
    logic        Branch = 1'b0;
    logic        Halt = 1'b0;
    logic        AluEq = 1'b0;
    logic        AluGt = 1'b0;
    logic        AluLt = 1'b0;
    logic        LutWe = 1'b0;
    logic [4:0]  LutAddr = 5'd0;
    logic [9:0]  LutData = 10'd0;
    logic [9:0]  InstAddr;
    logic        Running;
    logic        Done;
    logic [15:0] CycleCount;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 Clk = ~Clk;

    fetch_sequencer #(.PC_W(10), .LUT_DEPTH(32), .CNT_W(16)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Opcode     (Opcode),
        .TargetIdx  (TargetIdx),
        .Branch     (Branch),
        .Halt       (Halt),
        .AluEq      (AluEq),
        .AluGt      (AluGt),
        .AluLt      (AluLt),
        .LutWe      (LutWe),
        .LutAddr    (LutAddr),
        .LutData    (LutData),
        .InstAddr   (InstAddr),
        .Running    (Running),
        .Done       (Done),
        .CycleCount (CycleCount)
    );

    function automatic stim_t st(input logic start, input logic halt, input logic branch,
                                 input logic [3:0] op, input logic [4:0] idx,
                                 input logic eq, input logic gt, input logic lt);
        stim_t s;
        s = '0;
        s.start = start; s.halt = halt; s.branch = branch;
        s.op = op; s.idx = idx;
        s.eq = eq; s.gt = gt; s.lt = lt;
        return s;
    endfunction

    function automatic stim_t nop();
        return st(1'b0, 1'b0, 1'b0, 4'b0000, 5'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic stim_t wr(input logic [4:0] a, input logic [9:0] d);
        stim_t s;
        s = nop();
        s.we = 1'b1; s.waddr = a; s.wdata = d;
        return s;
    endfunction

    function automatic exp_t ex(input logic [9:0] a, input logic r, input logic d, input logic [15:0] c);
        exp_t e;
        e.addr = a; e.run = r; e.done = d; e.cnt = c;
        return e;
    endfunction

    task automatic drive_cycle(input stim_t s);
        Start = s.start; Halt = s.halt; Branch = s.branch;
        Opcode = s.op; TargetIdx = s.idx;
        AluEq = s.eq; AluGt = s.gt; AluLt = s.lt;
        LutWe = s.we; LutAddr = s.waddr; LutData = s.wdata;
        @(posedge Clk);
        #1;
        Start = 1'b0; Halt = 1'b0; Branch = 1'b0; LutWe = 1'b0;
        Opcode = 4'd0; TargetIdx = 5'd0;
        AluEq = 1'b0; AluGt = 1'b0; AluLt = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e, got;
        repeat (2) @(posedge Clk);
        #1;
        sb.push_back(ex(10'd0, 1'b0, 1'b0, 16'd0));
        e = sb.pop_front();
        got = {InstAddr, Running, Done, CycleCount};
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL reset: got addr=%0d run=%0b done=%0b cnt=%0d, expected addr=%0d run=%0b done=%0b cnt=%0d",
                     got.addr, got.run, got.done, got.cnt, e.addr, e.run, e.done, e.cnt);
        end
        #2 Reset = 1'b0;
        sb.push_back(ex(10'd0, 1'b0, 1'b0, 16'd0));
        drive_cycle(nop());
        e = sb.pop_front();
        got = {InstAddr, Running, Done, CycleCount};
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL idle_hold: got addr=%0d run=%0b done=%0b cnt=%0d, expected addr=%0d run=%0b done=%0b cnt=%0d",
                     got.addr, got.run, got.done, got.cnt, e.addr, e.run, e.done, e.cnt);
        end
    endtask

    task automatic test_lut_load();
        stim_t sv[$];
        exp_t e, got;
        sv.push_back(wr(5'd3, 10'd200));  sb.push_back(ex(10'd0, 1'b0, 1'b0, 16'd0));
        sv.push_back(wr(5'd4, 10'd300));  sb.push_back(ex(10'd0, 1'b0, 1'b0, 16'd0));
        sv.push_back(wr(5'd5, 10'd1023)); sb.push_back(ex(10'd0, 1'b0, 1'b0, 16'd0));
        sv.push_back(wr(5'd6, 10'd50));   sb.push_back(ex(10'd0, 1'b0, 1'b0, 16'd0));
        foreach (sv[i]) begin
            drive_cycle(sv[i]);
            e = sb.pop_front();
            got = {InstAddr, Running, Done, CycleCount};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL lut_load[%0d]: got addr=%0d run=%0b done=%0b cnt=%0d, expected addr=%0d run=%0b done=%0b cnt=%0d",
                         i, got.addr, got.run, got.done, got.cnt, e.addr, e.run, e.done, e.cnt);
            end
        end
    endtask

    task automatic test_straight();
        stim_t sv[$];
        exp_t e, got;
        sv.push_back(st(1'b1, 1'b0, 1'b0, 4'b0000, 5'd0, 1'b0, 1'b0, 1'b0));
        sb.push_back(ex(10'd0, 1'b1, 1'b0, 16'd0));
        for (int k = 1; k <= 5; k++) begin
            sv.push_back(nop());
            sb.push_back(ex(10'(k), 1'b1, 1'b0, 16'(k)));
        end
        foreach (sv[i]) begin
            drive_cycle(sv[i]);
            e = sb.pop_front();
            got = {InstAddr, Running, Done, CycleCount};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL straight[%0d]: got addr=%0d run=%0b done=%0b cnt=%0d, expected addr=%0d run=%0b done=%0b cnt=%0d",
                         i, got.addr, got.run, got.done, got.cnt, e.addr, e.run, e.done, e.cnt);
            end
        end
    endtask

    task automatic test_branches();
        stim_t sv[$];
        stim_t s;
        exp_t e, got;
        sv.push_back(st(1'b0, 1'b0, 1'b0, OP_CMP, 5'd0, 1'b1, 1'b0, 1'b0)); sb.push_back(ex(10'd6,   1'b1, 1'b0, 16'd6));
        sv.push_back(st(1'b0, 1'b0, 1'b1, OP_BEQ, 5'd3, 1'b0, 1'b0, 1'b0)); sb.push_back(ex(10'd200, 1'b1, 1'b0, 16'd7));
        sv.push_back(st(1'b0, 1'b0, 1'b0, OP_CMP, 5'd0, 1'b0, 1'b0, 1'b0)); sb.push_back(ex(10'd201, 1'b1, 1'b0, 16'd8));
        sv.push_back(st(1'b0, 1'b0, 1'b1, OP_BEQ, 5'd3, 1'b0, 1'b0, 1'b0)); sb.push_back(ex(10'd202, 1'b1, 1'b0, 16'd9));
        sv.push_back(st(1'b0, 1'b0, 1'b0, OP_CMP, 5'd0, 1'b0, 1'b1, 1'b0)); sb.push_back(ex(10'd203, 1'b1, 1'b0, 16'd10));
        sv.push_back(st(1'b0, 1'b0, 1'b1, OP_BGT, 5'd4, 1'b0, 1'b0, 1'b0)); sb.push_back(ex(10'd300, 1'b1, 1'b0, 16'd11));
        sv.push_back(st(1'b0, 1'b0, 1'b1, OP_BLT, 5'd4, 1'b0, 1'b0, 1'b0)); sb.push_back(ex(10'd301, 1'b1, 1'b0, 16'd12));
        sv.push_back(st(1'b0, 1'b0, 1'b0, OP_CMP, 5'd0, 1'b0, 1'b0, 1'b0)); sb.push_back(ex(10'd302, 1'b1, 1'b0, 16'd13));
        sv.push_back(st(1'b0, 1'b0, 1'b1, OP_BR,  5'd3, 1'b0, 1'b0, 1'b0)); sb.push_back(ex(10'd200, 1'b1, 1'b0, 16'd14));
        sv.push_back(st(1'b0, 1'b0, 1'b1, 4'b0011, 5'd3, 1'b0, 1'b0, 1'b0)); sb.push_back(ex(10'd201, 1'b1, 1'b0, 16'd15));
        sv.push_back(st(1'b0, 1'b0, 1'b0, OP_BR,  5'd3, 1'b0, 1'b0, 1'b0)); sb.push_back(ex(10'd202, 1'b1, 1'b0, 16'd16));
        // Table write to the entry being read this cycle: branch must see the old 200.
        s = st(1'b0, 1'b0, 1'b1, OP_BR, 5'd3, 1'b0, 1'b0, 1'b0);
        s.we = 1'b1; s.waddr = 5'd3; s.wdata = 10'd77;
        sv.push_back(s);                                                    sb.push_back(ex(10'd200, 1'b1, 1'b0, 16'd17));
        sv.push_back(nop());                                                sb.push_back(ex(10'd201, 1'b1, 1'b0, 16'd18));
        sv.push_back(st(1'b0, 1'b0, 1'b1, OP_BR,  5'd3, 1'b0, 1'b0, 1'b0)); sb.push_back(ex(10'd77,  1'b1, 1'b0, 16'd19));
        foreach (sv[i]) begin
            drive_cycle(sv[i]);
            e = sb.pop_front();
            got = {InstAddr, Running, Done, CycleCount};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL branch[%0d]: got addr=%0d run=%0b done=%0b cnt=%0d, expected addr=%0d run=%0b done=%0b cnt=%0d",
                         i, got.addr, got.run, got.done, got.cnt, e.addr, e.run, e.done, e.cnt);
            end
        end
    endtask

    task automatic test_wrap();
        stim_t sv[$];
        exp_t e, got;
        sv.push_back(st(1'b0, 1'b0, 1'b1, OP_BR, 5'd5, 1'b0, 1'b0, 1'b0)); sb.push_back(ex(10'd1023, 1'b1, 1'b0, 16'd20));
        sv.push_back(nop());                                               sb.push_back(ex(10'd0,    1'b1, 1'b0, 16'd21));
        sv.push_back(nop());                                               sb.push_back(ex(10'd1,    1'b1, 1'b0, 16'd22));
        foreach (sv[i]) begin
            drive_cycle(sv[i]);
            e = sb.pop_front();
            got = {InstAddr, Running, Done, CycleCount};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL wrap[%0d]: got addr=%0d run=%0b done=%0b cnt=%0d, expected addr=%0d run=%0b done=%0b cnt=%0d",
                         i, got.addr, got.run, got.done, got.cnt, e.addr, e.run, e.done, e.cnt);
            end
        end
    endtask

    task automatic test_halt();
        stim_t sv[$];
        exp_t e, got;
        sv.push_back(nop());                                                sb.push_back(ex(10'd2, 1'b1, 1'b0, 16'd23));
        sv.push_back(st(1'b0, 1'b0, 1'b0, OP_CMP, 5'd0, 1'b1, 1'b0, 1'b0)); sb.push_back(ex(10'd3, 1'b1, 1'b0, 16'd24));
        for (int k = 4; k <= 7; k++) begin
            sv.push_back(nop());
            sb.push_back(ex(10'(k), 1'b1, 1'b0, 16'(k + 21)));
        end
        // Halt together with an unconditional branch: halt has priority.
        sv.push_back(st(1'b0, 1'b1, 1'b1, OP_BR, 5'd3, 1'b0, 1'b0, 1'b0)); sb.push_back(ex(10'd7, 1'b0, 1'b1, 16'd29));
        sv.push_back(nop());                                               sb.push_back(ex(10'd7, 1'b0, 1'b1, 16'd29));
        sv.push_back(nop());                                               sb.push_back(ex(10'd7, 1'b0, 1'b1, 16'd29));
        foreach (sv[i]) begin
            drive_cycle(sv[i]);
            e = sb.pop_front();
            got = {InstAddr, Running, Done, CycleCount};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL halt[%0d]: got addr=%0d run=%0b done=%0b cnt=%0d, expected addr=%0d run=%0b done=%0b cnt=%0d",
                         i, got.addr, got.run, got.done, got.cnt, e.addr, e.run, e.done, e.cnt);
            end
        end
    endtask

    task automatic test_restart_from_done();
        stim_t sv[$];
        exp_t e, got;
        sv.push_back(st(1'b1, 1'b0, 1'b0, 4'b0000, 5'd0, 1'b0, 1'b0, 1'b0)); sb.push_back(ex(10'd0, 1'b1, 1'b0, 16'd0));
        // Flags were EQ before the halt; a cleared flag makes this BEQ fall through.
        sv.push_back(st(1'b0, 1'b0, 1'b1, OP_BEQ, 5'd3, 1'b0, 1'b0, 1'b0));  sb.push_back(ex(10'd1, 1'b1, 1'b0, 16'd1));
        foreach (sv[i]) begin
            drive_cycle(sv[i]);
            e = sb.pop_front();
            got = {InstAddr, Running, Done, CycleCount};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL restart_done[%0d]: got addr=%0d run=%0b done=%0b cnt=%0d, expected addr=%0d run=%0b done=%0b cnt=%0d",
                         i, got.addr, got.run, got.done, got.cnt, e.addr, e.run, e.done, e.cnt);
            end
        end
    endtask

    task automatic test_start_in_run();
        stim_t sv[$];
        exp_t e, got;
        sv.push_back(st(1'b0, 1'b0, 1'b0, OP_CMP, 5'd0, 1'b1, 1'b0, 1'b0));  sb.push_back(ex(10'd2,  1'b1, 1'b0, 16'd2));
        sv.push_back(st(1'b0, 1'b0, 1'b1, OP_BR,  5'd6, 1'b0, 1'b0, 1'b0));  sb.push_back(ex(10'd50, 1'b1, 1'b0, 16'd3));
        sv.push_back(st(1'b1, 1'b0, 1'b0, 4'b0000, 5'd0, 1'b0, 1'b0, 1'b0)); sb.push_back(ex(10'd0,  1'b1, 1'b0, 16'd0));
        sv.push_back(st(1'b0, 1'b0, 1'b1, OP_BEQ, 5'd3, 1'b0, 1'b0, 1'b0));  sb.push_back(ex(10'd1,  1'b1, 1'b0, 16'd1));
        foreach (sv[i]) begin
            drive_cycle(sv[i]);
            e = sb.pop_front();
            got = {InstAddr, Running, Done, CycleCount};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL start_in_run[%0d]: got addr=%0d run=%0b done=%0b cnt=%0d, expected addr=%0d run=%0b done=%0b cnt=%0d",
                         i, got.addr, got.run, got.done, got.cnt, e.addr, e.run, e.done, e.cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        stim_t sv[$];
        exp_t e, got;
        sb.push_back(ex(10'd2, 1'b1, 1'b0, 16'd2));
        drive_cycle(nop());
        e = sb.pop_front();
        got = {InstAddr, Running, Done, CycleCount};
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL pre_reset: got addr=%0d run=%0b done=%0b cnt=%0d, expected addr=%0d run=%0b done=%0b cnt=%0d",
                     got.addr, got.run, got.done, got.cnt, e.addr, e.run, e.done, e.cnt);
        end
        // Mid-cycle assertion; outputs must clear before the next rising edge.
        #2 Reset = 1'b1;
        sb.push_back(ex(10'd0, 1'b0, 1'b0, 16'd0));
        #1;
        e = sb.pop_front();
        got = {InstAddr, Running, Done, CycleCount};
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL async_reset: got addr=%0d run=%0b done=%0b cnt=%0d, expected addr=%0d run=%0b done=%0b cnt=%0d",
                     got.addr, got.run, got.done, got.cnt, e.addr, e.run, e.done, e.cnt);
        end
        @(posedge Clk);
        #3 Reset = 1'b0;
        sv.push_back(nop());                                                  sb.push_back(ex(10'd0, 1'b0, 1'b0, 16'd0));
        sv.push_back(st(1'b1, 1'b0, 1'b0, 4'b0000, 5'd0, 1'b0, 1'b0, 1'b0)); sb.push_back(ex(10'd0, 1'b1, 1'b0, 16'd0));
        sv.push_back(nop());                                                  sb.push_back(ex(10'd1, 1'b1, 1'b0, 16'd1));
        foreach (sv[i]) begin
            drive_cycle(sv[i]);
            e = sb.pop_front();
            got = {InstAddr, Running, Done, CycleCount};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL post_reset[%0d]: got addr=%0d run=%0b done=%0b cnt=%0d, expected addr=%0d run=%0b done=%0b cnt=%0d",
                         i, got.addr, got.run, got.done, got.cnt, e.addr, e.run, e.done, e.cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lut_load();
        test_straight();
        test_branches();
        test_wrap();
        test_halt();
        test_restart_from_done();
        test_start_in_run();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1);
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Front end of the 9-bit single-cycle core: owns the program counter, the CMP flag register and the run/halt handshake.
- Drives InstAddr into instruction memory.
- Takes Opcode, Branch and Halt back from the control decoder, plus ALU compare results, and resolves BEQ/BGT/BLT/BRANCH targets through an internal loadable lookup table.

Parameters:
- PC_W, 10, program counter / instruction address width.
- LUT_DEPTH, 32, branch target table entries; indexed by Inst[4:0].
- CNT_W, 16, width of the run cycle counter.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  level-sampled request to begin or restart a program run.
- Opcode  in  4  Inst[8:5] of the current instruction.
- TargetIdx  in  5  Inst[4:0]; branch table index.
- Branch  in  1  decoder branch-class indication.
- Halt  in  1  decoder halt indication.
- AluEq  in  1  compare result, operands equal.
- AluGt  in  1  compare result, operand A greater than operand B (unsigned).
- AluLt  in  1  compare result, operand A less than operand B (unsigned).
- LutWe  in  1  branch table write enable.
- LutAddr  in  5  branch table write index.
- LutData  in  PC_W  branch table write data.
- InstAddr  out  PC_W  current PC to instruction memory.
- Running  out  1  high in RUN; datapath gates register/memory writes with it.
- Done  out  1  high in DONE (program halted).
- CycleCount  out  CNT_W  cycles spent in RUN for the current run.

Behaviour:
- Reset (async):
  - State=IDLE; InstAddr=0; flags FlagEq/FlagGt/FlagLt=0; CycleCount=0; Running=0; Done=0.
  - Branch table contents are not reset.
- States IDLE, RUN, DONE. Running and Done are registered decodes of the state.
- IDLE:
  - Start=1 -> RUN next cycle; PC=0, flags=0, CycleCount=0.
  - Otherwise hold all state.
- RUN, evaluated each cycle in priority order:
  - Start=1: restart. PC=0, flags=0, CycleCount=0, stay in RUN.
  - Halt=1: -> DONE. PC holds at the halt instruction address. No flag update. Halt wins over Branch if both are high.
  - Taken branch: PC = LUT[TargetIdx].
    - Taken = Branch & ((Opcode==4'b1001 & FlagEq) | (Opcode==4'b1010 & FlagGt) | (Opcode==4'b1011 & FlagLt) | (Opcode==4'b1100)).
    - Branch=1 with any other opcode is not taken.
  - Otherwise: PC = PC+1, modulo 2^PC_W. Wraps from all-ones to 0 with no error.
- Flags:
  - Opcode==4'b0111 (CMP) in RUN and not Halt: flags <= {AluEq, AluGt, AluLt}. Visible to the branch in the next cycle.
  - Flags hold otherwise.
  - A CMP in the same cycle as a branch evaluation uses the old flags (cannot occur with legal decode).
- CycleCount:
  - Increments once per RUN cycle, including the halt cycle.
  - Saturates at all-ones.
  - Holds in DONE and IDLE.
- DONE:
  - Done=1 and PC holds.
  - Start=1 -> RUN with the same init as from IDLE.
  - Start held high continuously restarts every cycle in RUN. The bench must pulse Start.
- Branch table:
  - Synchronous write when LutWe=1, in any state.
  - Asynchronous read.
  - A write and a read to the same index in the same cycle returns the old entry.
- Reset asserted mid-run returns to IDLE immediately. Deassertion needs no Start-sync.

Decomposition:
- Shared package cpu_pkg: opcode constants (OP_CMP=4'b0111, OP_BEQ=4'b1001, OP_BGT=4'b1010, OP_BLT=4'b1011, OP_BR=4'b1100, OP_HALT=4'b1111) and the enum seq_state_t {IDLE, RUN, DONE}.
- The same opcode constants get used by the control decoder.
- One sub-module, branch_lut: LUT_DEPTH x PC_W register file, one write port and one async read port.

Test Plan:
- Reset, then Start pulse, straight-line code for 5 cycles -> InstAddr 0,1,2,3,4; Running=1; CycleCount=5.
- LUT[3]=10'd200; CMP with AluEq=1, then Branch with Opcode=1001, TargetIdx=3 -> next InstAddr=200.
- Repeat with AluEq=0 -> InstAddr = PC+1.
- BGT after CMP AluGt=1 -> taken to LUT entry. BLT after the same CMP -> not taken. BRANCH (1100) with flags=0 -> always taken.
- Halt at PC=7 -> Done=1 next cycle, InstAddr stays 7, CycleCount frozen.
- Start pulse from DONE -> PC=0, flags=0, counter=0, Running=1.
- PC forced to 1023 via LUT branch, then non-branch -> InstAddr wraps to 0.
- Assert Reset asynchronously mid-cycle during RUN -> outputs return to reset values before the next edge.
- Start pulse during RUN at PC=50 -> PC=0 and counter=0 next cycle.
